// File: rtl/drop_time_ctrl.sv
// Drop-time limit stage: latches height on start, computes t_lim = floor(sqrt(height*128))
// in Q4.4 with an iterative restoring square root, then tracks t_act against t_lim.
module drop_time_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] height,
  input  logic       start,
  input  logic [7:0] t_act,
  input  logic       drop_en,
  output logic [7:0] t_lim,
  output logic       t_lim_valid,
  output logic       busy,
  output logic [1:0] status,
  output logic       drop_activated
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQRT,
    S_ARMED,
    S_DROPPED
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_COLD = 2'b01,
    ST_HOT  = 2'b10,
    ST_DROP = 2'b11
  } status_t;

  state_t      state, state_n;
  status_t     status_q;
  logic [15:0] rad;
  logic [9:0]  rem;
  logic [7:0]  root;
  logic [2:0]  cnt;

  logic [11:0] rem_sh;
  logic [11:0] trial;
  logic        ge;
  logic [9:0]  rem_n;
  logic [7:0]  root_n;
  logic        reached;
  logic        restart;
  logic        last_iter;

  // One restoring step consumes the top two radicand bits per cycle.
  always_comb begin
    rem_sh = {rem, rad[15:14]};
    trial  = {2'b00, root, 2'b01};
    ge     = (rem_sh >= trial);
    rem_n  = ge ? 10'(rem_sh - trial) : rem_sh[9:0];
    root_n = {root[6:0], ge};
  end

  always_comb begin
    reached   = (t_act >= t_lim);
    restart   = start && (state != S_SQRT);
    last_iter = (cnt == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_SQRT;
      S_SQRT:    if (last_iter) state_n = S_ARMED;
      S_ARMED: begin
        if (start)                   state_n = S_SQRT;
        else if (reached && drop_en) state_n = S_DROPPED;
      end
      S_DROPPED: if (start) state_n = S_SQRT;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad            <= '0;
      rem            <= '0;
      root           <= '0;
      cnt            <= '0;
      t_lim          <= '0;
      t_lim_valid    <= 1'b0;
      busy           <= 1'b0;
      status_q       <= ST_NONE;
      drop_activated <= 1'b0;
    end else if (restart) begin
      // start outranks a coincident drop condition; t_lim keeps its old value.
      rad            <= {1'b0, height, 7'b0};
      rem            <= '0;
      root           <= '0;
      cnt            <= '0;
      t_lim_valid    <= 1'b0;
      busy           <= 1'b1;
      status_q       <= ST_NONE;
      drop_activated <= 1'b0;
    end else begin
      case (state)
        S_SQRT: begin
          rad  <= {rad[13:0], 2'b00};
          rem  <= rem_n;
          root <= root_n;
          cnt  <= cnt + 3'd1;
          if (last_iter) begin
            t_lim       <= root_n;
            t_lim_valid <= 1'b1;
            busy        <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!reached) begin
            status_q <= ST_COLD;
          end else if (drop_en) begin
            status_q       <= ST_DROP;
            drop_activated <= 1'b1;
          end else begin
            status_q <= ST_HOT;
          end
        end
        default: ;
      endcase
    end
  end

  assign status = status_q;

endmodule

// File: tb/tb_drop_time_ctrl.sv
// Directed bench for drop_time_ctrl: hand-computed sqrt results, status sequencing,
// restart/ignore behaviour and asynchronous reset mid-computation.
module tb_drop_time_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] height;
  logic       start;
  logic [7:0] t_act;
  logic       drop_en;
  logic [7:0] t_lim;
  logic       t_lim_valid;
  logic       busy;
  logic [1:0] status;
  logic       drop_activated;

  int unsigned n_checks;
  int unsigned n_passed;

  drop_time_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .height         (height),
    .start          (start),
    .t_act          (t_act),
    .drop_en        (drop_en),
    .t_lim          (t_lim),
    .t_lim_valid    (t_lim_valid),
    .busy           (busy),
    .status         (status),
    .drop_activated (drop_activated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] h);
    height = h;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_t_lim"}, 16'(t_lim), 16'h00);
    check({tag, "_valid"}, 16'(t_lim_valid), 16'h0);
    check({tag, "_busy"},  16'(busy), 16'h0);
    check({tag, "_status"}, 16'(status), 16'h0);
    check({tag, "_drop"},  16'(drop_activated), 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    rst_n   = 1'b0;
    height  = 8'd0;
    start   = 1'b0;
    t_act   = 8'd0;
    drop_en = 1'b0;
    #23;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    // height=2 -> 0x10, HOT, then DROP when enabled
    t_act = 8'h20;
    pulse_start(8'd2);
    check("h2_busy_e0", 16'(busy), 16'h1);
    tick(7);
    check("h2_valid_e7", 16'(t_lim_valid), 16'h0);
    check("h2_busy_e7", 16'(busy), 16'h1);
    tick(1);
    check("h2_t_lim", 16'(t_lim), 16'h10);
    check("h2_valid_e8", 16'(t_lim_valid), 16'h1);
    check("h2_busy_e8", 16'(busy), 16'h0);
    check("h2_status_e8", 16'(status), 16'h0);
    tick(1);
    check("h2_status_hot", 16'(status), 16'h2);
    check("h2_drop_pre", 16'(drop_activated), 16'h0);
    drop_en = 1'b1;
    tick(1);
    check("h2_status_drop", 16'(status), 16'h3);
    check("h2_drop", 16'(drop_activated), 16'h1);
    drop_en = 1'b0;
    t_act   = 8'h00;
    tick(2);
    check("h2_hold_status", 16'(status), 16'h3);
    check("h2_hold_drop", 16'(drop_activated), 16'h1);

    // height=100 -> 0x71, COLD, drop exactly when t_act reaches 0x71
    t_act = 8'h50;
    pulse_start(8'd100);
    check("h100_drop_clr", 16'(drop_activated), 16'h0);
    check("h100_status_clr", 16'(status), 16'h0);
    check("h100_t_lim_kept", 16'(t_lim), 16'h10);
    tick(8);
    check("h100_t_lim", 16'(t_lim), 16'h71);
    tick(1);
    check("h100_cold", 16'(status), 16'h1);
    drop_en = 1'b1;
    t_act   = 8'h70;
    tick(1);
    check("h100_cold_70", 16'(status), 16'h1);
    check("h100_nodrop_70", 16'(drop_activated), 16'h0);
    t_act = 8'h71;
    tick(1);
    check("h100_drop_71", 16'(status), 16'h3);
    check("h100_dropact_71", 16'(drop_activated), 16'h1);

    // height=255 -> 0xB4
    drop_en = 1'b0;
    pulse_start(8'd255);
    tick(8);
    check("h255_t_lim", 16'(t_lim), 16'hB4);

    // height=0 -> 0x00, HOT immediately
    t_act = 8'h00;
    pulse_start(8'd0);
    tick(8);
    check("h0_t_lim", 16'(t_lim), 16'h00);
    tick(1);
    check("h0_hot", 16'(status), 16'h2);

    // start coinciding with drop condition: start wins; then height=50 with ignored restart
    drop_en = 1'b1;
    pulse_start(8'd50);
    check("coinc_nodrop", 16'(drop_activated), 16'h0);
    check("coinc_busy", 16'(busy), 16'h1);
    check("coinc_status", 16'(status), 16'h0);
    drop_en = 1'b0;
    tick(2);
    pulse_start(8'd200);
    height = 8'd77;
    tick(5);
    check("h50_t_lim", 16'(t_lim), 16'h50);
    check("h50_valid", 16'(t_lim_valid), 16'h1);
    tick(1);
    check("h50_busy_after", 16'(busy), 16'h0);
    check("h50_cold", 16'(status), 16'h1);

    // reach DROPPED, then restart with height=8
    t_act   = 8'h60;
    drop_en = 1'b1;
    tick(1);
    check("h50_drop", 16'(drop_activated), 16'h1);
    drop_en = 1'b0;
    pulse_start(8'd8);
    check("h8_drop_clr", 16'(drop_activated), 16'h0);
    check("h8_valid_clr", 16'(t_lim_valid), 16'h0);
    check("h8_t_lim_kept", 16'(t_lim), 16'h50);
    tick(8);
    check("h8_t_lim", 16'(t_lim), 16'h20);
    tick(1);
    check("h8_hot", 16'(status), 16'h2);
    t_act = 8'h10;
    tick(1);
    check("h8_cold", 16'(status), 16'h1);

    // asynchronous reset at E4 of a computation
    pulse_start(8'd100);
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #3;
    rst_n = 1'b1;
    tick(12);
    check_reset_vals("post_rst_idle");

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
